bitwise_shift_arbiter: RTL and testbench
========================================

# bitwise_shift_arbiter

Shares a single combinational shift-left datapath (a BitWiseShiftMUX-based log-shifter, N bits, O = log2(N) stage selects) between R requesters. Each requester presents an operand and shift amount with a valid/ready handshake. The arbiter grants one request per cycle, shifts it, and holds the result in a one-entry output register tagged with the requester index. It sits between the BasicCombinationalLogic shift unit and any client blocks that would otherwise each instantiate their own shifter.

## Interface
- N, 8, operand/result width; power of two, N >= 2
- O, $clog2(N), shift-amount width
- R, 2, number of requesters; R >= 2
- I, $clog2(R), requester-index width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous and active-high
- req_valid  input  R  bit r: requester r presents a request
- req_a  input  R*N  operand of requester r at [r*N +: N]
- req_b  input  R*O  shift amount of requester r at [r*O +: O]
- req_ready  output  R  one-hot or zero; bit r: request r accepted this cycle
- rsp_valid  output  1  result register holds a valid result
- rsp_c  output  N  shifted result
- rsp_id  output  I  index of the requester that produced rsp_c
- rsp_ready  input  1  consumer accepts the result this cycle

## Operation
- Output register state: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- Slot available when rsp_valid==0, or when rsp_valid==1 and rsp_ready==1 in the same cycle (pass-through refill).
- When the slot is available and any req_valid is set, exactly one requester g is granted, and req_ready[g]=1 combinationally in that cycle. All other bits are 0. No grant is made when the slot is unavailable.
- Grant g is chosen by the arbitration policy (see Configuration).
- On grant: rsp_c <= req_a[g] << req_b[g], truncated to N bits with zero fill (identical to the structural shifter output); rsp_id <= g; rsp_valid <= 1.
- Slot consumed with no new grant: rsp_valid <= 0. rsp_c and rsp_id hold their last values.
- FULL and rsp_ready==0: rsp_valid, rsp_c and rsp_id are held stable; all req_ready are 0.
- req_b covers 0..N-1; b=0 passes a unchanged.
- Requesters must hold req_valid, req_a and req_b stable until accepted. Deasserting req_valid before acceptance drops the request silently.
- Round-robin pointer ptr (I bits, range 0..R-1): after a grant to g, ptr <= (g+1) mod R, wrapping from R-1 to 0. ptr is unchanged in cycles with no grant.

## Timing
- Reset (rst=1 at an edge): rsp_valid=0, rsp_c=0, rsp_id=0, ptr=0. req_ready is 0 during any cycle in which rst=1.
- Reset mid-operation discards a held result and the pointer state. No request is accepted in the reset cycle.
- Latency: a request accepted at edge t appears on rsp_* after edge t, i.e. one cycle.
- Throughput: one result per cycle while rsp_ready stays 1.
- req_ready depends combinationally on req_valid, rsp_valid, rsp_ready and ptr. It has no dependency on req_a or req_b.
- rsp_* outputs are registered only.

## Configuration
- Macro BITWISE_SHIFT_ARB_RR_EN.
- Defined: round-robin arbitration. The first valid requester scanning ptr, ptr+1, …, wrapping modulo R, is granted.
- Undefined: fixed priority. The lowest-index valid requester is granted. ptr is not implemented, and requester 0 can starve the others.

## Test plan
- Reset: drive rst=1 with all req_valid=1 → req_ready=0; after release, rsp_valid=0, rsp_c=0, rsp_id=0.
- Single request, N=8, R=2: req 0 with a=8'hB5, b=3 and rsp_ready=1 → req_ready=2'b01; next cycle rsp_valid=1, rsp_c=8'hA8, rsp_id=0.
- Boundary shifts: a=8'hFF with b=0 → 8'hFF; a=8'hFF with b=7 → 8'h80; a=8'h01 with b=7 → 8'h80.
- Backpressure: hold rsp_ready=0 for 3 cycles with both requesters valid → rsp_* stable and req_ready=0 throughout. Raise rsp_ready → exactly one grant per cycle resumes.
- Contention, R=4, all valid, rsp_ready=1 for 8 cycles:
  - RR defined: rsp_id sequence 0,1,2,3,0,1,2,3.
  - RR undefined: rsp_id sequence 0,0,0,…
- Reset while FULL with rsp_ready=0 → rsp_valid=0 next cycle. The next grant under RR goes to requester 0.

Source files
------------

// File: rtl/bitwise_shift_arbiter.sv
// bitwise_shift_arbiter: shares one log-shifter (shift-left, zero fill)
// between R requesters. One grant per cycle into a one-entry result register
// tagged with the requester index.
// Build option: define BITWISE_SHIFT_ARB_RR_EN for round-robin arbitration;
// otherwise the lowest-index valid requester wins (fixed priority).
module bitwise_shift_arbiter #(
  parameter int N = 8,
  parameter int R = 2,
  parameter int O = $clog2(N),
  parameter int I = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_a,
  input  logic [R*O-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic           rsp_valid,
  output logic [N-1:0]   rsp_c,
  output logic [I-1:0]   rsp_id,
  input  logic           rsp_ready
);

  logic           slot_avail;
  logic           grant_any;
  logic [I-1:0]   grant_idx;
  logic [N-1:0]   sel_a;
  logic [O-1:0]   sel_b;
  logic [N-1:0]   shifted;

`ifdef BITWISE_SHIFT_ARB_RR_EN
  logic [I-1:0]   ptr;
`endif

  // The slot can take a new result when empty or when it drains this cycle.
  assign slot_avail = !rsp_valid || rsp_ready;

  // Pick the winner; scanning downward leaves the first match in scan order.
  always_comb begin
    int s;
    s         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (!rst && slot_avail) begin
      for (int k = R - 1; k >= 0; k--) begin
`ifdef BITWISE_SHIFT_ARB_RR_EN
        s = int'(ptr) + k;
        if (s >= R) s = s - R;
`else
        s = k;
`endif
        if (req_valid[I'(s)]) begin
          grant_any = 1'b1;
          grant_idx = I'(s);
        end
      end
    end
  end

  assign req_ready = grant_any ? (R'(1) << grant_idx) : '0;

  // Route the winner's operands into the shared shifter.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int r = 0; r < R; r++) begin
      if (I'(r) == grant_idx) begin
        sel_a = req_a[r*N +: N];
        sel_b = req_b[r*O +: O];
      end
    end
  end

  // Log-shifter: stage j shifts by 2**j when select bit j is set.
  always_comb begin
    shifted = sel_a;
    for (int j = 0; j < O; j++) begin
      if (sel_b[j]) shifted = shifted << (1 << j);
    end
  end

`ifdef BITWISE_SHIFT_ARB_RR_EN
  // Advance the round-robin pointer past each winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_any) begin
      if (grant_idx == I'(R - 1)) ptr <= '0;
      else                        ptr <= grant_idx + I'(1);
    end
  end
`endif

  // One-entry result register; data holds when the slot simply drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_id    <= '0;
    end else if (grant_any) begin
      rsp_valid <= 1'b1;
      rsp_c     <= shifted;
      rsp_id    <= grant_idx;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_shift_arbiter.sv
// Scoreboard bench for bitwise_shift_arbiter (R=4, N=8). Follows the
// BITWISE_SHIFT_ARB_RR_EN build option of the design under test.
module tb_bitwise_shift_arbiter;
  localparam int N = 8;
  localparam int R = 4;
  localparam int O = 3;
  localparam int I = 2;
`ifdef BITWISE_SHIFT_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_a;
  logic [R*O-1:0] req_b;
  logic [R-1:0]   req_ready;
  logic           rsp_valid;
  logic [N-1:0]   rsp_c;
  logic [I-1:0]   rsp_id;
  logic           rsp_ready;

  bitwise_shift_arbiter #(.N(N), .R(R)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_c(rsp_c),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int q_id[$];
  int q_c[$];
  bit m_full = 1'b0;
  int m_ptr  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // First valid requester in the order p, p+1, ... wrapping; -1 if none.
  function automatic int pick(input logic [R-1:0] v, input int p);
    for (int k = 0; k < R; k++) begin
      int idx;
      idx = (p + k) % R;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Drive one cycle, check req_ready/rsp_valid, then advance the model.
  task automatic step(input bit r, input logic [R-1:0] v,
                      input logic [R*N-1:0] a, input logic [R*O-1:0] b,
                      input bit rr);
    int g;
    int exp_ready;
    @(negedge clk);
    rst = r; req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    g = -1;
    if (!r && (!m_full || rr)) g = pick(v, RR_MODE ? m_ptr : 0);
    exp_ready = (g >= 0) ? (1 << g) : 0;
    #1;
    check("req_ready", int'(req_ready), exp_ready);
    check("rsp_valid", int'(rsp_valid), int'(m_full));
    #2;
    if (r) begin
      q_id.delete(); q_c.delete();
      m_full = 1'b0; m_ptr = 0;
    end else if (g >= 0) begin
      int av, bv;
      av = int'(a[g*N +: N]);
      bv = int'(b[g*O +: O]);
      q_id.push_back(g);
      q_c.push_back((av * (1 << bv)) % (1 << N));
      m_full = 1'b1;
      m_ptr  = (g + 1) % R;
    end else if (rr) begin
      m_full = 1'b0;
    end
  endtask

  // Monitor: compare a presented result against the scoreboard head; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid) begin
        if (q_id.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rsp: got id %0d c %0h expected no result", rsp_id, rsp_c);
        end else begin
          check("rsp_id", int'(rsp_id), q_id[0]);
          check("rsp_c", int'(rsp_c), q_c[0]);
          if (rsp_ready) begin
            void'(q_id.pop_front());
            void'(q_c.pop_front());
          end
        end
      end
    end
  end

  task automatic single(input int id, input logic [N-1:0] a, input logic [O-1:0] b,
                        input logic [N-1:0] exp);
    logic [R*N-1:0] av;
    logic [R*O-1:0] bv;
    av = '0; bv = '0;
    av[id*N +: N] = a;
    bv[id*O +: O] = b;
    step(1'b0, R'(1) << id, av, bv, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0);
    check("single_c", int'(rsp_c), int'(exp));
    check("single_id", int'(rsp_id), id);
  endtask

  initial begin
    logic [R*N-1:0] ra;
    logic [R*O-1:0] rb;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // Reset with every requester asking: nothing may be granted.
    step(1'b1, '1, '1, '1, 1'b1);
    step(1'b1, '1, '1, '1, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1);
    check("reset_rsp_c", int'(rsp_c), 0);
    check("reset_rsp_id", int'(rsp_id), 0);

    // Contention: all valid for 8 cycles with the consumer always ready.
    for (int k = 0; k <= 8; k++) begin
      step(1'b0, (k < 8) ? {R{1'b1}} : '0, {R{8'h5A}}, {R{3'd1}}, 1'b1);
      if (k > 0) check("contention_id", int'(rsp_id), RR_MODE ? (k - 1) % R : 0);
    end

    // Single request from requester 0: 0xB5 << 3.
    step(1'b0, 4'b0001, {24'h0, 8'hB5}, {9'h0, 3'd3}, 1'b1);
    check("single_ready", int'(req_ready), 1);
    step(1'b0, '0, '0, '0, 1'b0);
    check("single_b5", int'(rsp_c), 8'hA8);
    check("single_b5_id", int'(rsp_id), 0);

    // Shift boundaries on assorted requesters.
    single(1, 8'hFF, 3'd0, 8'hFF);
    single(2, 8'hFF, 3'd7, 8'h80);
    single(3, 8'h01, 3'd7, 8'h80);
    single(0, 8'hC3, 3'd4, 8'h30);

    // Backpressure: result held and nothing granted for 3 cycles, then resume.
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0011, {R{8'h11}}, {R{3'd2}}, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 4'b0011, {R{8'h11}}, {R{3'd2}}, 1'b1);

    // Reset while full and stalled; next grant restarts from requester 0.
    step(1'b0, 4'b1111, {R{8'h07}}, {R{3'd1}}, 1'b1);
    step(1'b0, 4'b1111, {R{8'h07}}, {R{3'd1}}, 1'b0);
    step(1'b1, 4'b1111, {R{8'h07}}, {R{3'd1}}, 1'b0);
    step(1'b0, 4'b1110, {R{8'h07}}, {R{3'd1}}, 1'b0);
    check("post_reset_grant_skip0", int'(req_ready), 2);
    step(1'b0, '0, '0, '0, 1'b1);
    step(1'b1, '0, '0, '0, 1'b0);
    step(1'b0, 4'b1111, {R{8'h07}}, {R{3'd1}}, 1'b0);
    check("post_reset_grant0", int'(req_ready), 1);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      ra = {$urandom, $urandom};
      rb = R*O'($urandom);
      step($urandom_range(0, 59) == 0, R'($urandom), ra, rb, $urandom_range(0, 3) != 0);
    end

    // Drain.
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, '0, 1'b1);
    check("scoreboard_empty", q_id.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
